// File: rtl/rs_codec_pkg.sv
// Shared RS codec definitions: code geometry, framer state encoding, byte order.
// Latency: none (types, constants and a pure lane-select function only).
// Backpressure: none.
//
// Contents
//   RS_N / RS_K     : RS(255,239) codeword and information lengths in bytes
//   framer_state_e  : encode-side framer FSM states
//   MSB_FIRST       : lane order of bytes inside a 32-bit word; the decode-side
//                     8->32 packer uses the same constant so both ends agree
//   word_lane()     : picks byte lane idx (0 = first on the wire) from a word
package rs_codec_pkg;

  localparam int unsigned RS_N = 255;
  localparam int unsigned RS_K = 239;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAD   = 2'd2
  } framer_state_e;

  // Lane 0 on the wire is word[31:24] when set.
  localparam bit MSB_FIRST = 1'b1;

  function automatic logic [7:0] word_lane(input logic [31:0] word, input logic [1:0] idx);
    logic [1:0] lane;
    lane = MSB_FIRST ? (2'd3 - idx) : idx;
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rs_enc_framer_if.sv
// AXI-Stream link (tdata/tvalid/tlast/tready) of configurable data width.
// Latency: none (wires only).
// Backpressure: tready from the slave side stalls the master.
//
// Modports
//   master : drives tdata, tvalid, tlast; samples tready
//   slave  : samples tdata, tvalid, tlast; drives tready
interface rs_enc_framer_if #(
  parameter int DW = 8
);

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_word_to_byte.sv
// 32->8 serialiser datapath: holds one word plus its last flag and walks the byte lanes.
// Latency: a word loaded at cycle N presents lane 0 at N+1.
// Backpressure: lanes advance only on adv_i; the caller decides when a load is legal.
//
// Ports
//   core_clk, rst : clock, synchronous active-high reset
//   load_i        : capture word_i/last_i and restart at lane 0 (wins over adv_i)
//   word_i/last_i : incoming word and its end-of-message flag
//   adv_i         : current lane has been consumed; step to the next one
//   byte_o        : current lane of the held word
//   idx_o         : current lane index 0..3
//   last_o        : end-of-message flag of the held word
// Occupancy is tracked by the owning FSM, so no valid flag is kept here.
module axis_word_to_byte
  import rs_codec_pkg::*;
(
  input  logic        core_clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        last_i,
  input  logic        adv_i,
  output logic [7:0]  byte_o,
  output logic [1:0]  idx_o,
  output logic        last_o
);

  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    last_d = last_q;
    idx_d  = idx_q;
    if (load_i) begin
      // A load coincides with the handshake of the previous word's lane 3,
      // so it must take precedence over the advance.
      word_d = word_i;
      last_d = last_i;
      idx_d  = 2'd0;
    end else if (adv_i) begin
      idx_d = idx_q + 2'd1;  // 3 wraps to 0; the FSM leaves SHIFT at that point
    end
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      word_q <= '0;
      last_q <= 1'b0;
      idx_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      last_q <= last_d;
      idx_q  <= idx_d;
    end
  end

  assign byte_o = word_lane(word_q, idx_q);
  assign idx_o  = idx_q;
  assign last_o = last_q;

endmodule

// File: rtl/rs_enc_framer.sv
// RS encode front end: serialises 32-bit message words to bytes and cuts K_BYTES-byte frames,
// zero-padding the final partial frame. Latency: word accepted at N -> byte 0 valid at N+1.
// Backpressure: m tready stalls the byte stream; s tready is high only in IDLE or on the lane-3 handshake.
//
// Parameters
//   K_BYTES     : information bytes per frame, 2..255 (default RS_K = 239)
//   PAD_BYTE    : byte value emitted while filling a partial final frame
//   FRAME_CNT_W : width of frame_count (16 in the encode path; narrower only for quick wrap checks)
// Ports
//   core_clk    : single clock
//   rst         : synchronous active-high reset; drops the held word and any partial frame
//   s_axis      : 32-bit message stream in (slave); tdata lane 0 = [31:24], tlast ends a message
//   m_axis      : 8-bit byte stream out (master) to the RS encoder; tlast marks a frame's final byte
//   frame_count : frames completed (tlast handshakes), wrapping
//   pad_active  : high while a PAD_BYTE is presented
module rs_enc_framer
  import rs_codec_pkg::*;
#(
  parameter int unsigned K_BYTES     = RS_K,
  parameter logic [7:0]  PAD_BYTE    = 8'h00,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   core_clk,
  input  logic                   rst,
  rs_enc_framer_if.slave         s_axis,
  rs_enc_framer_if.master        m_axis,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   pad_active
);

  localparam logic [7:0] CNT_LAST = 8'(K_BYTES - 1);

  framer_state_e          state_q, state_d;
  logic [7:0]             byte_cnt_q, byte_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [7:0] ser_byte;
  logic [1:0] ser_idx;
  logic       ser_last;

  logic       s_rdy;
  logic       m_vld;
  logic       m_last;
  logic [7:0] m_dat;
  logic       pad_on;
  logic       s_hs;
  logic       m_hs;
  logic       frame_end;

  // byte_cnt runs independently of the lane index: a word may straddle two
  // frames whenever K_BYTES is not a multiple of four.
  assign frame_end = (byte_cnt_q == CNT_LAST);
  assign s_hs      = s_axis.tvalid && s_rdy;
  assign m_hs      = m_vld && m_axis.tready;

  axis_word_to_byte u_ser (
    .core_clk (core_clk),
    .rst      (rst),
    .load_i   (s_hs),
    .word_i   (s_axis.tdata),
    .last_i   (s_axis.tlast),
    .adv_i    (m_hs && (state_q == SHIFT)),
    .byte_o   (ser_byte),
    .idx_o    (ser_idx),
    .last_o   (ser_last)
  );

  // Next state and outputs, all decoded from registered state so the
  // m-side signals hold steady while the encoder stalls.
  always_comb begin
    state_d = state_q;
    s_rdy   = 1'b0;
    m_vld   = 1'b0;
    m_last  = 1'b0;
    m_dat   = 8'h00;
    pad_on  = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_rdy = 1'b1;
        if (s_axis.tvalid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        m_vld  = 1'b1;
        m_dat  = ser_byte;
        m_last = frame_end;
        // Refill in the same cycle lane 3 leaves, keeping 1 byte/cycle.
        // A last-flagged word never refills: the frame must be closed first.
        if ((ser_idx == 2'd3) && !ser_last) begin
          s_rdy = m_axis.tready;
        end
        if (m_axis.tready && (ser_idx == 2'd3)) begin
          if (ser_last) begin
            state_d = frame_end ? IDLE : PAD;
          end else if (!s_axis.tvalid) begin
            // Word drained with no successor yet; the frame stays open.
            state_d = IDLE;
          end
        end
      end
      PAD: begin
        m_vld  = 1'b1;
        m_dat  = PAD_BYTE;
        m_last = frame_end;
        pad_on = 1'b1;
        if (m_axis.tready && frame_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (m_hs) begin
      if (frame_end) begin
        byte_cnt_d  = 8'd0;
        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      end else begin
        byte_cnt_d = byte_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= 8'd0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = m_vld;
  assign m_axis.tdata  = m_dat;
  assign m_axis.tlast  = m_last;
  assign frame_count   = frame_cnt_q;
  assign pad_active    = pad_on;

endmodule
